// File: rtl/trans_ingress_fifo.sv
// trans_ingress_fifo: assembles four 32-bit words into one 128-bit transaction,
// queues completed transactions and presents the head as a registered
// valid/ack request for the transaction validator.
// Optional feature: define TRANS_INGRESS_SELF_DROP_EN to discard transactions
// whose sender id equals the receiver id (adds the drop_o pulse output).
module trans_ingress_fifo #(
    parameter int DEPTH     = 16,
    parameter int ERR_CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              in_data,
    input  logic                     in_valid,
    input  logic                     in_sot,
    output logic                     in_ready,
    output logic [127:0]             data_o,
    output logic                     valid_o,
    input  logic                     ack_i,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [ERR_CNT_W-1:0]     frame_err_o
`ifdef TRANS_INGRESS_SELF_DROP_EN
    ,
    output logic                     drop_o
`endif
);
    localparam int AW = $clog2(DEPTH);

    logic [127:0]         r_mem [DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [AW:0]          r_level;
    logic [95:0]          r_asm;
    logic [1:0]           r_word_idx;
    logic [ERR_CNT_W-1:0] r_frame_err;
    logic                 r_valid;
    logic [127:0]         r_data;

    logic                 w_full;
    logic                 w_acc;
    logic [127:0]         w_txn;
    logic                 w_complete;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_frame_err;
    logic [AW-1:0]        w_rptr_nxt;
    logic [AW:0]          w_level_nxt;
    logic [AW:0]          w_after_pop;
    logic [127:0]         w_head_nxt;

    assign w_full      = (r_level == (AW+1)'(DEPTH));
    assign in_ready    = rst_n && !w_full;
    assign w_acc       = in_valid && in_ready;
    // Word 3 is pushed straight from the input bus, so no 4th slice register.
    assign w_txn       = {r_asm, in_data};
    // A start-of-transaction word at index 3 restarts framing instead of completing.
    assign w_complete  = w_acc && !in_sot && (r_word_idx == 2'd3);
    assign w_pop       = ack_i && r_valid;
    assign w_frame_err = w_acc && (in_sot ? (r_word_idx != 2'd0) : (r_word_idx == 2'd0));

`ifdef TRANS_INGRESS_SELF_DROP_EN
    logic w_self;
    logic r_drop;
    assign w_self = (w_txn[127:80] == w_txn[79:32]);
    assign w_push = w_complete && !w_self;
    assign drop_o = r_drop;

    // One-cycle pulse after a self-addressed transaction is discarded
    always_ff @(posedge clk) begin
        if (!rst_n) r_drop <= 1'b0;
        else        r_drop <= w_complete && w_self;
    end
`else
    assign w_push = w_complete;
`endif

    assign w_rptr_nxt  = w_pop ? r_rptr + AW'(1) : r_rptr;
    assign w_after_pop = r_level - {{AW{1'b0}}, w_pop};

    // Next occupancy and next head; bypass the write when it lands in an empty queue
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push, w_pop})
            2'b10:   w_level_nxt = r_level + (AW+1)'(1);
            2'b01:   w_level_nxt = r_level - (AW+1)'(1);
            default: w_level_nxt = r_level;
        endcase
        w_head_nxt = r_mem[w_rptr_nxt];
        if (w_push && (w_after_pop == '0)) w_head_nxt = w_txn;
    end

    // Word assembly and framing-error counting
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_asm       <= '0;
            r_word_idx  <= 2'd0;
            r_frame_err <= '0;
        end else if (w_acc) begin
            if (in_sot) begin
                r_asm[95:64] <= in_data;
                r_word_idx   <= 2'd1;
            end else if (r_word_idx != 2'd0) begin
                case (r_word_idx)
                    2'd1:    r_asm[63:32] <= in_data;
                    2'd2:    r_asm[31:0]  <= in_data;
                    default: ;
                endcase
                r_word_idx <= r_word_idx + 2'd1;
            end
            if (w_frame_err && !(&r_frame_err))
                r_frame_err <= r_frame_err + ERR_CNT_W'(1);
        end
    end

    // Queue storage; contents need no reset since level gates visibility
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wptr] <= w_txn;
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + AW'(1);
            r_rptr  <= w_rptr_nxt;
            r_level <= w_level_nxt;
        end
    end

    // Registered head; data only reloads on pop or first fill, so it holds until ack
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            r_valid <= (w_level_nxt != '0);
            if (w_level_nxt != '0) r_data <= w_head_nxt;
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign level_o     = r_level;
    assign frame_err_o = r_frame_err;

endmodule

// File: tb/tb_trans_ingress_fifo.sv
// Scoreboard bench for trans_ingress_fifo: stimulus pushes expected
// transactions, a monitor thread pops and compares on every accepted ack.
module tb_trans_ingress_fifo;
    localparam int DEPTH = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [31:0]  in_data;
    logic         in_valid;
    logic         in_sot;
    logic         in_ready;
    logic [127:0] data_o;
    logic         valid_o;
    logic         ack_i;
    logic [4:0]   level_o;
    logic [15:0]  frame_err_o;
`ifdef TRANS_INGRESS_SELF_DROP_EN
    logic         drop_o;
`endif

    int checks = 0;
    int errors = 0;
    int pops = 0;
    int max_level = 0;
    logic [127:0] sb [$];

    always #5 clk = ~clk;

    trans_ingress_fifo #(.DEPTH(DEPTH), .ERR_CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
        .in_sot(in_sot), .in_ready(in_ready), .data_o(data_o), .valid_o(valid_o),
        .ack_i(ack_i), .level_o(level_o), .frame_err_o(frame_err_o)
`ifdef TRANS_INGRESS_SELF_DROP_EN
        , .drop_o(drop_o)
`endif
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    function automatic logic [127:0] mk(input int k);
        logic [31:0] kk;
        kk = 32'(k);
        return {32'hC0DE0000 + kk, 32'h00001000 + kk, 32'hABCD0000 + kk, 32'h00000200 + kk};
    endfunction

    task automatic send_word(input logic [31:0] d, input logic sot);
        int n;
        n = 0;
        in_data = d; in_valid = 1'b1; in_sot = sot;
        while (!in_ready && n < 200) begin tick(); n++; end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1 within 200 cycles");
        end
        tick();
        in_valid = 1'b0; in_sot = 1'b0;
    endtask

    task automatic send_txn(input logic [127:0] t, input logic exp_push);
        if (exp_push) sb.push_back(t);
        send_word(t[127:96], 1'b1);
        send_word(t[95:64],  1'b0);
        send_word(t[63:32],  1'b0);
        send_word(t[31:0],   1'b0);
    endtask

    task automatic monitor();
        logic [127:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && valid_o && ack_i) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_pop: got %0h expected no entry", data_o);
                end else begin
                    e = sb.pop_front();
                    chk("sb_data", data_o, e);
                end
                pops++;
            end
            if (int'(level_o) > max_level) max_level = int'(level_o);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] t1, tb_, tc, td, ts;
        int base;
        rst_n = 1'b0; in_data = '0; in_valid = 1'b0; in_sot = 1'b0; ack_i = 1'b0;
        fork monitor(); join_none
        repeat (3) tick();

        // reset state
        chk("rst_valid", valid_o, 0);
        chk("rst_level", level_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_ferr", frame_err_o, 0);
        chk("rst_in_ready", in_ready, 0);
        rst_n = 1'b1;
        tick();
        chk("ready_after_rst", in_ready, 1);

        // single transaction
        t1 = 128'hAAAA0000_0001BBBB_00000002_00000A00;
        send_txn(t1, 1'b1);
        chk("t1_valid", valid_o, 1);
        chk("t1_data", data_o, t1);
        chk("t1_level", level_o, 1);
        ack_i = 1'b1; tick(); ack_i = 1'b0;
        chk("t1_valid_after_ack", valid_o, 0);
        chk("t1_level_after_ack", level_o, 0);

        // fill and backpressure
        for (int k = 0; k < DEPTH; k++) begin
            send_txn(mk(k), 1'b1);
            if (k == 8) chk("fill_head_mid", data_o, mk(0));
        end
        chk("full_level", level_o, 16);
        chk("full_in_ready", in_ready, 0);
        chk("full_head", data_o, mk(0));
        ack_i = 1'b1; tick(); ack_i = 1'b0;
        chk("after_ack_in_ready", in_ready, 1);
        chk("after_ack_head", data_o, mk(1));
        chk("after_ack_level", level_o, 15);
        ack_i = 1'b1; repeat (15) tick(); ack_i = 1'b0;
        chk("drained_level", level_o, 0);
        chk("drained_valid", valid_o, 0);
        chk("drained_sb", 128'(sb.size()), 0);

        // wrap: 40 transactions, ack every 3rd cycle
        base = pops;
        fork
            begin
                for (int k = 0; k < 40; k++) send_txn(mk(100 + k), 1'b1);
            end
            begin
                int cyc;
                cyc = 0;
                while (pops < base + 40 && cyc < 3000) begin
                    tick(); cyc++;
                    ack_i = (cyc % 3 == 0);
                end
                ack_i = 1'b0;
            end
        join
        chk("wrap_pops", 128'(pops - base), 40);
        chk("wrap_sb_empty", 128'(sb.size()), 0);
        chk("wrap_max_level", 128'(max_level <= DEPTH), 1);
        tick();

        // framing: partial then restart
        send_word(32'h11111111, 1'b1);
        send_word(32'h22222222, 1'b0);
        tb_ = 128'h0BBB0000_00020CCC_00000003_00000400;
        send_txn(tb_, 1'b1);
        chk("frame_err_restart", frame_err_o, 1);
        chk("frame_valid", valid_o, 1);
        chk("frame_data", data_o, tb_);
        chk("frame_level", level_o, 1);
        ack_i = 1'b1; tick(); ack_i = 1'b0;
        chk("frame_valid_after_ack", valid_o, 0);
        send_word(32'hDEADBEEF, 1'b0);
        chk("frame_err_stray", frame_err_o, 2);
        chk("frame_stray_level", level_o, 0);

        // simultaneous push and pop at level 1
        tc = 128'h0CCC0000_00030DDD_00000004_00000600;
        td = 128'h0DDD0000_00040EEE_00000005_00000800;
        send_txn(tc, 1'b1);
        chk("sim_level_pre", level_o, 1);
        sb.push_back(td);
        send_word(td[127:96], 1'b1);
        send_word(td[95:64], 1'b0);
        send_word(td[63:32], 1'b0);
        ack_i = 1'b1;
        send_word(td[31:0], 1'b0);
        ack_i = 1'b0;
        chk("sim_level", level_o, 1);
        chk("sim_data", data_o, td);
        chk("sim_valid", valid_o, 1);
        ack_i = 1'b1; tick(); ack_i = 1'b0;
        chk("sim_level_post", level_o, 0);

        // self-addressed transaction
        ts = 128'h12345678_9ABC1234_56789ABC_00000A00;
`ifdef TRANS_INGRESS_SELF_DROP_EN
        send_txn(ts, 1'b0);
        chk("drop_pulse", drop_o, 1);
        chk("drop_valid", valid_o, 0);
        chk("drop_level", level_o, 0);
        tick();
        chk("drop_pulse_end", drop_o, 0);
`else
        send_txn(ts, 1'b1);
        chk("self_valid", valid_o, 1);
        chk("self_data", data_o, ts);
        ack_i = 1'b1; tick(); ack_i = 1'b0;
        chk("self_level_post", level_o, 0);
`endif
        tick();
        chk("final_sb_empty", 128'(sb.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
